fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 191 +++++++++++++++++++
 tb/tb_fb_scanout.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Framebuffer scanout: video timing, 64-bit word fetch FIFO, pixel output.
// Optional sticky underflow flag: define FB_SCANOUT_UNDERFLOW_EN.
module fb_scanout #(
  parameter int H_ACTIVE   = 720,
  parameter int V_ACTIVE   = 480,
  parameter int H_TOTAL    = 858,
  parameter int V_TOTAL    = 525,
  parameter int HS_START   = 736,
  parameter int HS_END     = 798,
  parameter int VS_START   = 489,
  parameter int VS_END     = 495,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_pix,
  output logic [27:0] fb_addr,
  output logic        fb_rd,
  input  logic        fb_ready,
  input  logic [63:0] fb_data,
  output logic [7:0]  pix,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        hblank,
  output logic        vblank,
  output logic        underflow
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [24:0] LAST_W = 25'(H_ACTIVE * V_ACTIVE / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FLUSH
  } st_t;

  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [2:0]    idx_q;
  logic [24:0]   waddr_q;
  st_t           st_q;

  logic h_wrap, v_wrap, act_c, realign_c;
  logic empty_c, full_c, push_c, take_c, pop_c;
  logic [7:0] head_byte;

  assign h_wrap    = h_cnt_q == HW'(H_TOTAL - 1);
  assign v_wrap    = v_cnt_q == VW'(V_TOTAL - 1);
  assign act_c     = (h_cnt_q < HW'(H_ACTIVE)) &&
                     (v_cnt_q < VW'(V_ACTIVE));
  assign realign_c = ce_pix && h_wrap &&
                     (v_cnt_q == VW'(V_ACTIVE - 1));

  assign empty_c   = cnt_q == '0;
  assign full_c    = cnt_q == (AW+1)'(FIFO_DEPTH);
  // A word arriving on the realign cycle belongs to the old frame.
  assign push_c    = (st_q == S_REQ) && fb_ready && !realign_c;
  assign take_c    = ce_pix && act_c && !empty_c;
  assign pop_c     = take_c && (idx_q == 3'd7);
  assign head_byte = mem_q[rd_ptr_q][{idx_q, 3'b000} +: 8];

  // Raster counters, starting in vertical blanking after reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= VW'(V_ACTIVE);
    end else if (ce_pix) begin
      h_cnt_q <= h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap)
        v_cnt_q <= v_wrap ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Registered video outputs for the current raster position.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      de     <= 1'b0;
      hs     <= 1'b0;
      vs     <= 1'b0;
      hblank <= 1'b0;
      vblank <= 1'b1;
      pix    <= 8'h00;
    end else if (ce_pix) begin
      de     <= act_c;
      hs     <= (h_cnt_q >= HW'(HS_START)) &&
                (h_cnt_q < HW'(HS_END));
      vs     <= (v_cnt_q >= VW'(VS_START)) &&
                (v_cnt_q < VW'(VS_END));
      hblank <= h_cnt_q >= HW'(H_ACTIVE);
      vblank <= v_cnt_q >= VW'(V_ACTIVE);
      pix    <= take_c ? head_byte : 8'h00;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_sys) begin
    if (push_c)
      mem_q[wr_ptr_q] <= fb_data;
  end

  // FIFO pointers, occupancy and byte index; realign empties it.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || realign_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      if (push_c)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_c)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_c}
                     - {{AW{1'b0}}, pop_c};
      if (take_c)
        idx_q <= idx_q + 3'd1;
    end
  end

  // Fetch FSM: one outstanding read, flushes a read straddling realign.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      st_q    <= S_IDLE;
      waddr_q <= '0;
      fb_rd   <= 1'b0;
      fb_addr <= '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (realign_c) begin
            waddr_q <= '0;
          end else if (!full_c && waddr_q < LAST_W) begin
            st_q    <= S_REQ;
            fb_rd   <= 1'b1;
            fb_addr <= {waddr_q, 3'b000};
          end
        end
        S_REQ: begin
          if (realign_c) begin
            waddr_q <= '0;
            if (fb_ready) begin
              st_q  <= S_IDLE;
              fb_rd <= 1'b0;
            end else begin
              st_q  <= S_FLUSH;
            end
          end else if (fb_ready) begin
            st_q    <= S_IDLE;
            fb_rd   <= 1'b0;
            waddr_q <= waddr_q + 25'd1;
          end
        end
        S_FLUSH: begin
          if (realign_c)
            waddr_q <= '0;
          if (fb_ready) begin
            st_q  <= S_IDLE;
            fb_rd <= 1'b0;
          end
        end
        default: begin
          st_q  <= S_IDLE;
          fb_rd <= 1'b0;
        end
      endcase
    end
  end

`ifdef FB_SCANOUT_UNDERFLOW_EN
  logic uf_q;
  // Sticky: a due pixel found the FIFO empty.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      uf_q <= 1'b0;
    else if (ce_pix && act_c && empty_c)
      uf_q <= 1'b1;
  end
  assign underflow = uf_q;
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a reduced raster.
// Pixel n of a frame is expected to be pix_of(n).
module tb_fb_scanout;

  localparam int HA  = 32;
  localparam int VA  = 6;
  localparam int HT  = 48;
  localparam int VT  = 10;
  localparam int HSS = 36;
  localparam int HSE = 40;
  localparam int VSS = 7;
  localparam int VSE = 8;
  localparam int FD  = 4;
  localparam int WORDS = HA * VA / 8;

`ifdef FB_SCANOUT_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic        fb_ready = 1'b0;
  logic [27:0] fb_addr;
  logic        fb_rd;
  logic [63:0] fb_data;
  logic [7:0]  pix;
  logic        hs, vs, de, hblank, vblank, underflow;

  fb_scanout #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
    .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_ready(fb_ready),
    .fb_data(fb_data), .pix(pix), .hs(hs), .vs(vs), .de(de),
    .hblank(hblank), .vblank(vblank), .underflow(underflow)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] pix_of(int n);
    return 8'((n * 37 + 11) & 255);
  endfunction

  // Framebuffer memory model: byte b of word w is pixel 8w+b.
  always_comb begin
    fb_data = '0;
    for (int b = 0; b < 8; b++)
      fb_data[b*8 +: 8] = pix_of(int'(fb_addr[27:3]) * 8 + b);
  end

  typedef struct {
    logic de, hs, vs, hb, vb;
    logic [7:0] pix;
    int mode;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int k = 0;
  bit dirty = 0;
  bit starve = 0;
  int acc_n = 0;
  logic [27:0] acc_addr = '0;
  exp_t me;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  // Drive one cycle; log read handshakes; push the expected response.
  task automatic step(input bit ce, input bit rdy);
    exp_t e;
    int h, v;
    @(negedge clk_sys);
    ce_pix = ce;
    fb_ready = rdy;
    if (reset_n && fb_rd && rdy) begin
      acc_n++;
      acc_addr = fb_addr;
      chk("addr_align", {29'd0, fb_addr[2:0]}, 32'd0);
      chk("addr_bound", {31'd0, int'(fb_addr[27:3]) < WORDS}, 32'd1);
    end
    if (reset_n && ce) begin
      h = k % HT;
      v = (VA + k / HT) % VT;
      e.de = (h < HA) && (v < VA);
      e.hs = (h >= HSS) && (h < HSE);
      e.vs = (v >= VSS) && (v < VSE);
      e.hb = h >= HA;
      e.vb = v >= VA;
      e.pix = e.de ? pix_of(v * HA + h) : 8'h00;
      e.mode = starve ? 1 : (dirty ? 2 : 0);
      if (starve)
        e.pix = 8'h00;
      q.push_back(e);
      if (h == HT - 1 && v == VA - 1)
        dirty = 0;
      k++;
    end
  endtask

  task automatic rstep();
    step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
  endtask

  task automatic run_to(int th, int tv, bit full_ce, bit no_rdy);
    for (int i = 0; i < 5000; i++) begin
      if (k % HT == th && (VA + k / HT) % VT == tv)
        return;
      if (full_ce || no_rdy)
        step(full_ce ? 1'b1 : ($urandom_range(0, 9) < 7),
             no_rdy ? 1'b0 : ($urandom_range(0, 9) < 7));
      else
        rstep();
    end
    fail("run_to");
  endtask

  task automatic wait_acc(string name, logic [27:0] exp);
    int n0;
    n0 = acc_n;
    for (int i = 0; i < 200 && acc_n == n0; i++)
      step($urandom_range(0, 9) < 7, 1'b1);
    if (acc_n == n0)
      fail(name);
    else
      chk(name, {4'd0, acc_addr}, {4'd0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    ce_pix = 1'b0;
    fb_ready = 1'b0;
    q.delete();
    @(posedge clk_sys);
    #2;
    chk("rst_fb_rd", {31'd0, fb_rd}, 32'd0);
    chk("rst_fb_addr", {4'd0, fb_addr}, 32'd0);
    chk("rst_pix", {24'd0, pix}, 32'd0);
    chk("rst_de", {31'd0, de}, 32'd0);
    chk("rst_hs", {31'd0, hs}, 32'd0);
    chk("rst_vs", {31'd0, vs}, 32'd0);
    chk("rst_hblank", {31'd0, hblank}, 32'd0);
    chk("rst_vblank", {31'd0, vblank}, 32'd1);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    k = 0;
    dirty = 0;
    starve = 0;
  endtask

  // Monitor: compare each pixel-enabled edge against the scoreboard.
  always @(posedge clk_sys) begin
    if (reset_n && ce_pix) begin
      #1;
      if (q.size() == 0) begin
        fail("sb_empty");
      end else begin
        me = q.pop_front();
        chk("de", {31'd0, de}, {31'd0, me.de});
        chk("hs", {31'd0, hs}, {31'd0, me.hs});
        chk("vs", {31'd0, vs}, {31'd0, me.vs});
        chk("hblank", {31'd0, hblank}, {31'd0, me.hb});
        chk("vblank", {31'd0, vblank}, {31'd0, me.vb});
        if (me.mode != 2 || !me.de)
          chk("pix", {24'd0, pix}, {24'd0, me.pix});
      end
    end
  end

  initial begin
    do_reset();
    wait_acc("first_addr", 28'd0);

    repeat (2) begin
      run_to(0, 0, 0, 0);
      run_to(0, VA, 0, 0);
    end
    chk("uf_clean", {31'd0, underflow}, 32'd0);

    run_to(0, 0, 0, 0);
    dirty = 1;
    for (int i = 0; i < 200; i++) begin
      starve = (i >= 60);
      step(1'b1, 1'b0);
    end
    starve = 0;
    run_to(0, VA, 0, 0);
    chk("uf_starve", {31'd0, underflow}, {31'd0, UF_EXP});
    run_to(0, 0, 0, 0);
    run_to(0, VA, 0, 0);

    run_to(0, VA - 2, 0, 0);
    dirty = 1;
    run_to(0, VA, 1, 1);
    repeat (3) step(1'b1, 1'b0);
    chk("flush_hold_rd", {31'd0, fb_rd}, 32'd1);
    step(1'b1, 1'b1);
    wait_acc("addr_after_flush", 28'd0);
    run_to(0, 0, 0, 0);
    run_to(0, VA, 0, 0);

    run_to(0, 1, 0, 0);
    for (int i = 0; i < 50 && !fb_rd; i++)
      step(1'b1, 1'b0);
    chk("rd_before_reset", {31'd0, fb_rd}, 32'd1);
    do_reset();
    wait_acc("addr_after_reset", 28'd0);
    run_to(0, 0, 0, 0);
    run_to(0, VA, 0, 0);
    chk("uf_after_reset", {31'd0, underflow}, 32'd0);

    step(1'b0, 1'b0);
    repeat (2) @(negedge clk_sys);
    chk("sb_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
